// File: rtl/cpu32_alu_pkg.sv
// Shared ALU definitions: comparator width and the {id, y} response packing.
package cpu32_alu_pkg;

   localparam int unsigned CMP_W = 32;

   // Width of a packed response {id, y} for a given id width.
   function automatic int unsigned rsp_w(input int unsigned idw);
      return idw + CMP_W;
   endfunction

endpackage

// File: rtl/cmp_arb_skid2.sv
// Two-entry FIFO holding packed {id, y} responses; only built with CMP_ARB_SKID_EN.
`ifdef CMP_ARB_SKID_EN
import cpu32_alu_pkg::*;

module cmp_arb_skid2 #(
   parameter int unsigned W = 33
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         valid,
   input  logic         ready,
   output logic [W-1:0] dout
);

   logic [W-1:0] mem0;
   logic [W-1:0] mem1;
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count;
   logic         do_push;
   logic         do_pop;

   assign valid   = (count != 2'd0);
   assign full    = (count == 2'd2);
   assign do_push = push && !full;
   assign do_pop  = valid && ready;
   assign dout    = rd_ptr ? mem1 : mem0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem0   <= '0;
         mem1   <= '0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            if (wr_ptr) mem1 <= din;
            else        mem0 <= din;
            wr_ptr <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
`endif

// File: rtl/slt32.sv
// 32-bit less-than comparator, signed or unsigned per transaction.
import cpu32_alu_pkg::*;

module slt32 (
   input  logic [CMP_W-1:0] a,
   input  logic [CMP_W-1:0] b,
   input  logic             uns,
   output logic             lt
);

   always_comb begin
      lt = 1'b0;
      if (uns) lt = (a < b);
      else     lt = ($signed(a) < $signed(b));
   end

endmodule

// File: rtl/cmp_share_arb.sv
// Round-robin arbiter sharing one slt32 between N_REQ requesters with a registered, id-tagged result.
// Define CMP_ARB_SKID_EN to replace the output register with a 2-entry FIFO (req_ready then ignores rsp_ready).
import cpu32_alu_pkg::*;

module cmp_share_arb #(
   parameter int unsigned N_REQ = 2,
   parameter int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [CMP_W*N_REQ-1:0] req_a,
   input  logic [CMP_W*N_REQ-1:0] req_b,
   input  logic [N_REQ-1:0]       req_unsigned,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [CMP_W-1:0]       rsp_y,
   output logic [IDW-1:0]         rsp_id
);

   localparam int unsigned RW = rsp_w(IDW);

   logic [IDW-1:0]   rr_ptr;
   logic [N_REQ-1:0] grant;
   logic [IDW-1:0]   gnt_idx;
   logic             gnt_any;
   logic             can_accept;
   logic             push;
   logic [CMP_W-1:0] a_sel;
   logic [CMP_W-1:0] b_sel;
   logic             uns_sel;
   logic             lt;

   // Scan lanes starting at rr_ptr; first valid lane wins.
   always_comb begin
      grant   = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!gnt_any && req_valid[i] && (i == (32'(rr_ptr) + k) % N_REQ)) begin
               gnt_any  = 1'b1;
               gnt_idx  = IDW'(i);
               grant[i] = 1'b1;
            end
         end
      end
   end

   assign push      = rst_n && can_accept && gnt_any;
   assign req_ready = (rst_n && can_accept) ? grant : '0;

   always_comb begin
      a_sel   = '0;
      b_sel   = '0;
      uns_sel = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            a_sel   = req_a[i*CMP_W +: CMP_W];
            b_sel   = req_b[i*CMP_W +: CMP_W];
            uns_sel = req_unsigned[i];
         end
      end
   end

   slt32 u_slt (
      .a   (a_sel),
      .b   (b_sel),
      .uns (uns_sel),
      .lt  (lt)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)    rr_ptr <= '0;
      else if (push) rr_ptr <= (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
   end

`ifdef CMP_ARB_SKID_EN
   logic          full;
   logic [RW-1:0] head;

   assign can_accept = !full;

   cmp_arb_skid2 #(.W(RW)) u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({gnt_idx, {(CMP_W-1){1'b0}}, lt}),
      .full  (full),
      .valid (rsp_valid),
      .ready (rsp_ready),
      .dout  (head)
   );

   assign rsp_y  = head[CMP_W-1:0];
   assign rsp_id = head[RW-1:CMP_W];
`else
   logic           vld_q;
   logic           lt_q;
   logic [IDW-1:0] id_q;

   // Single output register; reloads on a simultaneous pop and push.
   assign can_accept = !vld_q || rsp_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         lt_q  <= 1'b0;
         id_q  <= '0;
      end else if (push) begin
         vld_q <= 1'b1;
         lt_q  <= lt;
         id_q  <= gnt_idx;
      end else if (rsp_ready) begin
         vld_q <= 1'b0;
      end
   end

   assign rsp_valid = vld_q;
   assign rsp_y     = {{(CMP_W-1){1'b0}}, lt_q};
   assign rsp_id    = id_q;
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Directed self-checking bench for cmp_share_arb with three requesters.
module tb_cmp_share_arb;

   localparam int unsigned N   = 3;
   localparam int unsigned IDW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [32*N-1:0] req_a;
   logic [32*N-1:0] req_b;
   logic [N-1:0]    req_unsigned;
   logic            rsp_valid;
   logic            rsp_ready;
   logic [31:0]     rsp_y;
   logic [IDW-1:0]  rsp_id;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cmp_share_arb #(.N_REQ(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_unsigned (req_unsigned),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_y        (rsp_y),
      .rsp_id       (rsp_id)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] b, input logic u);
      req_a[32*i +: 32] = a;
      req_b[32*i +: 32] = b;
      req_unsigned[i]   = u;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = '1;
      rsp_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_ready got %b want 000", req_ready); end
         n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", rsp_valid); end
         n_checks++; if (rsp_y !== 32'd0) begin n_fail++; $display("FAIL reset_y got %h want 0", rsp_y); end
         n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_id got %0d want 0", rsp_id); end
      end
      rst_n     = 1'b1;
      req_valid = '0;
      step();
   endtask

   task automatic test_single_lane();
      rsp_ready = 1'b1;
      req_valid = 3'b001;
      set_lane(0, 32'hFFFF_FFFF, 32'd1, 1'b0);
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready_s got %b want 001", req_ready); end
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_s got %b want 1", rsp_valid); end
      n_checks++; if (rsp_y !== 32'd1) begin n_fail++; $display("FAIL single_y_signed got %h want 1", rsp_y); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id_s got %0d want 0", rsp_id); end
      req_unsigned[0] = 1'b1;
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL single_ready_u got %b want 001", req_ready); end
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid_u got %b want 1", rsp_valid); end
      n_checks++; if (rsp_y !== 32'd0) begin n_fail++; $display("FAIL single_y_unsigned got %h want 0", rsp_y); end
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_id_u got %0d want 0", rsp_id); end
      req_valid = '0;
      step();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain got %b want 0", rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] one;
      logic [N-1:0] exp_rdy;
      logic [31:0]  exp_y [3];
      int           lane;
      exp_y[0] = 32'd1;
      exp_y[1] = 32'd0;
      exp_y[2] = 32'd1;
      one = 3'b001;
      do_reset();
      set_lane(0, 32'd1, 32'd2, 1'b0);
      set_lane(1, 32'd5, 32'd3, 1'b0);
      set_lane(2, 32'hFFFF_FFFF, 32'd0, 1'b0);
      rsp_ready = 1'b1;
      req_valid = 3'b111;
      for (int c = 0; c < 6; c++) begin
         lane    = c % 3;
         exp_rdy = one << lane;
         #1;
         n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready[%0d] got %b want %b", c, req_ready, exp_rdy); end
         step();
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b want 1", c, rsp_valid); end
         n_checks++; if (rsp_id !== IDW'(lane)) begin n_fail++; $display("FAIL rr_id[%0d] got %0d want %0d", c, rsp_id, lane); end
         n_checks++; if (rsp_y !== exp_y[lane]) begin n_fail++; $display("FAIL rr_y[%0d] got %h want %h", c, rsp_y, exp_y[lane]); end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_backpressure();
      int n_stall;
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 3'b010;
      set_lane(1, 32'd2, 32'd9, 1'b1);
      #1;
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_first_ready got %b want 010", req_ready); end
      step();
      set_lane(1, 32'd9, 32'd2, 1'b1);
`ifdef CMP_ARB_SKID_EN
      #1;
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_second_ready got %b want 010", req_ready); end
      step();
      set_lane(1, 32'd3, 32'd4, 1'b1);
      n_stall = 2;
`else
      n_stall = 3;
`endif
      for (int c = 0; c < n_stall; c++) begin
         #1;
         n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_stall_ready[%0d] got %b want 000", c, req_ready); end
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid[%0d] got %b want 1", c, rsp_valid); end
         n_checks++; if (rsp_y !== 32'd1) begin n_fail++; $display("FAIL bp_stall_y[%0d] got %h want 1", c, rsp_y); end
         n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_stall_id[%0d] got %0d want 1", c, rsp_id); end
         step();
      end
      rsp_ready = 1'b1;
      #1;
`ifdef CMP_ARB_SKID_EN
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL bp_release_ready got %b want 000", req_ready); end
`else
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_release_ready got %b want 010", req_ready); end
`endif
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid got %b want 1", rsp_valid); end
      n_checks++; if (rsp_y !== 32'd0) begin n_fail++; $display("FAIL bp_second_y got %h want 0", rsp_y); end
      n_checks++; if (rsp_id !== 2'd1) begin n_fail++; $display("FAIL bp_second_id got %0d want 1", rsp_id); end
      set_lane(1, 32'd3, 32'd4, 1'b1);
      #1;
      n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL bp_third_ready got %b want 010", req_ready); end
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_third_valid got %b want 1", rsp_valid); end
      n_checks++; if (rsp_y !== 32'd1) begin n_fail++; $display("FAIL bp_third_y got %h want 1", rsp_y); end
      req_valid = '0;
      step();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained got %b want 0", rsp_valid); end
   endtask

   task automatic test_boundary();
      logic [31:0] va [6];
      logic [31:0] vb [6];
      logic        vu [6];
      logic [31:0] vy [6];
      va[0] = 32'h8000_0000; vb[0] = 32'h7FFF_FFFF; vu[0] = 1'b0; vy[0] = 32'd1;
      va[1] = 32'h8000_0000; vb[1] = 32'h7FFF_FFFF; vu[1] = 1'b1; vy[1] = 32'd0;
      va[2] = 32'h1234_5678; vb[2] = 32'h1234_5678; vu[2] = 1'b0; vy[2] = 32'd0;
      va[3] = 32'h1234_5678; vb[3] = 32'h1234_5678; vu[3] = 1'b1; vy[3] = 32'd0;
      va[4] = 32'h7FFF_FFFF; vb[4] = 32'h8000_0000; vu[4] = 1'b0; vy[4] = 32'd0;
      va[5] = 32'h7FFF_FFFF; vb[5] = 32'h8000_0000; vu[5] = 1'b1; vy[5] = 32'd1;
      rsp_ready = 1'b1;
      req_valid = 3'b001;
      for (int v = 0; v < 6; v++) begin
         set_lane(0, va[v], vb[v], vu[v]);
         step();
         n_checks++; if (rsp_y !== vy[v]) begin n_fail++; $display("FAIL bound_y[%0d] got %h want %h", v, rsp_y, vy[v]); end
         n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bound_valid[%0d] got %b want 1", v, rsp_valid); end
      end
      req_valid = '0;
      step();
   endtask

   task automatic test_midop_reset();
      do_reset();
      rsp_ready = 1'b0;
      req_valid = 3'b001;
      set_lane(0, 32'd1, 32'd2, 1'b0);
      step();
      n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", rsp_valid); end
      rst_n     = 1'b0;
      req_valid = 3'b111;
      #1;
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL mid_rst_ready got %b want 000", req_ready); end
      step();
      n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b want 0", rsp_valid); end
      n_checks++; if (rsp_y !== 32'd0) begin n_fail++; $display("FAIL mid_y got %h want 0", rsp_y); end
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      #1;
      n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL mid_lane0_wins got %b want 001", req_ready); end
      step();
      n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL mid_id got %0d want 0", rsp_id); end
      req_valid = '0;
      step();
   endtask

   initial begin
      rst_n        = 1'b0;
      req_valid    = '0;
      req_a        = '0;
      req_b        = '0;
      req_unsigned = '0;
      rsp_ready    = 1'b0;
      test_reset();
      test_single_lane();
      test_round_robin();
      test_backpressure();
      test_boundary();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
